// File: rtl/ieee_sp_int_to_fp.sv
// 32-bit integer to IEEE 754 single-precision converter, four-stage pipeline,
// truncating (round-toward-zero), with a global stall driven by out_ready.
module ieee_sp_int_to_fp #(
    parameter int SIGNED_IN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Int_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Result,
    output logic        inexact
);

    // Leading-zero count; zero input returns 0 and is flagged separately.
    function automatic logic [4:0] lzc32(input logic [31:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = 5'(31 - i);
        end
        return n;
    endfunction

    // Truncating pack; norm[31] is clear only for a zero operand.
    function automatic logic [32:0] pack_trunc(input logic        sign,
                                               input logic [4:0]  lzc,
                                               input logic [31:0] norm);
        logic [7:0] e;
        e = 8'd158 - {3'b000, lzc};
        if (!norm[31]) return 33'd0;
        return {|norm[7:0], sign, e, norm[30:8]};
    endfunction

    logic        w_en;
    logic        w_sign_p0;
    logic [31:0] w_mag_p0;
    logic [32:0] w_pack_p3;

    logic        r_vld_p1, r_vld_p2, r_vld_p3;
    logic        r_sign_p1, r_sign_p2, r_sign_p3;
    logic [31:0] r_mag_p1, r_mag_p2;
    logic [4:0]  r_lzc_p2, r_lzc_p3;
    logic        r_zero_p2;
    logic [31:0] r_norm_p3;

    assign w_en      = out_ready | ~out_valid;
    assign in_ready  = w_en;
    assign w_sign_p0 = Int_in[31] & (SIGNED_IN != 0);
    assign w_mag_p0  = w_sign_p0 ? (~Int_in + 32'd1) : Int_in;
    assign w_pack_p3 = pack_trunc(r_sign_p3, r_lzc_p3, r_norm_p3);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_vld_p3  <= 1'b0;
            out_valid <= 1'b0;
            Result    <= 32'd0;
            inexact   <= 1'b0;
        end else if (w_en) begin
            r_vld_p1  <= in_valid;
            r_vld_p2  <= r_vld_p1;
            r_vld_p3  <= r_vld_p2;
            out_valid <= r_vld_p3;
            if (r_vld_p3) begin
                inexact <= w_pack_p3[32];
                Result  <= w_pack_p3[31:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            // S1: sign / magnitude
            r_sign_p1 <= w_sign_p0;
            r_mag_p1  <= w_mag_p0;
            // S2: leading-one search
            r_sign_p2 <= r_sign_p1;
            r_mag_p2  <= r_mag_p1;
            r_lzc_p2  <= lzc32(r_mag_p1);
            r_zero_p2 <= (r_mag_p1 == 32'd0);
            // S3: normalize
            r_sign_p3 <= r_sign_p2;
            r_lzc_p3  <= r_lzc_p2;
            r_norm_p3 <= r_zero_p2 ? 32'd0 : (r_mag_p2 << r_lzc_p2);
        end
    end

endmodule
